// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: streams one picture from a 1-cycle-latency memory to a ready/valid consumer.
// Optional feature macro PIXEL_CLASS_EN adds a registered pixel_class output.
module pixel_stream_tx #(
  parameter int PIX_NUM = 16384,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       pixel_out,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              last_pixel,
`ifdef PIXEL_CLASS_EN
  output logic [1:0]        pixel_class,
`endif
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIX_NUM - 1);
  state_t state;
  logic rd_vld, rd_last, skid_vld, skid_last, xfer, adv, at_last, nxt_avail, nxt_last;
  logic [23:0] skid, nxt_pix;
  logic [1:0] occ;
  assign xfer = pixel_valid & pixel_ready;
  assign adv = ~pixel_valid | pixel_ready;
  assign at_last = mem_addr == LAST;
  assign nxt_avail = skid_vld | rd_vld;
  assign nxt_pix = skid_vld ? skid : mem_rdata;
  assign nxt_last = skid_vld ? skid_last : rd_last;
  // pixels still owed to the consumer after this cycle's transfer (returning read + held pixels)
  assign occ = 2'(rd_vld) + 2'(pixel_valid) + 2'(skid_vld) - 2'(xfer);
  // the start cycle itself reads address 0; in RUN at most two pixels may be outstanding
  assign mem_rd_en = reset & ~abort & (state == IDLE ? start : (state == RUN && occ < 2'd2));
  // control FSM and address counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mem_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      mem_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (mem_rd_en && !at_last) mem_addr <= mem_addr + ADDR_W'(1);
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
        end
        RUN: if (mem_rd_en && at_last) state <= DRAIN;
        DRAIN: if (xfer && last_pixel) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          mem_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  // output register with a one-entry skid buffer catching the read that returns during a stall
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_vld <= 1'b0;
      rd_last <= 1'b0;
      pixel_out <= '0;
      pixel_valid <= 1'b0;
      last_pixel <= 1'b0;
      skid <= '0;
      skid_vld <= 1'b0;
      skid_last <= 1'b0;
    end else if (abort) begin
      rd_vld <= 1'b0;
      rd_last <= 1'b0;
      pixel_valid <= 1'b0;
      last_pixel <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      rd_vld <= mem_rd_en;
      rd_last <= mem_rd_en & at_last;
      if (adv) begin
        pixel_valid <= nxt_avail;
        last_pixel <= nxt_avail & nxt_last;
        if (nxt_avail) pixel_out <= nxt_pix;
      end
      skid_vld <= adv ? skid_vld & rd_vld : skid_vld | rd_vld;
      if (rd_vld) begin
        skid <= mem_rdata;
        skid_last <= rd_last;
      end
    end
`ifdef PIXEL_CLASS_EN
  logic [7:0] r, g, b;
  logic [1:0] nxt_class;
  assign {r, g, b} = nxt_pix;
  assign nxt_class = (g >= b && g > r) ? 2'b01 : (b > g && b > r) ? 2'b10 : 2'b00;
  // colour class registered together with pixel_out
  always_ff @(posedge clk or negedge reset)
    if (!reset) pixel_class <= 2'b00;
    else if (!abort && adv && nxt_avail) pixel_class <= nxt_class;
`endif
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: three DUTs (PIX_NUM 4, 8, 16) checked against a picture-level reference model.
module tb_pixel_stream_tx;
  logic clk = 1'b0, reset;
  logic [2:0] start, abort, ready, rd_en, valid, last, busy, done;
  logic [2:0][13:0] addr;
  logic [2:0][23:0] pout;
`ifdef PIXEL_CLASS_EN
  logic [2:0][1:0] pclass;
  logic [1:0] o_cls;
  logic [1:0] q_cls[$];
`endif
  logic [23:0] mem[3][16];
  int vec = 0, bad = 0;
  logic o_rd, o_valid, o_last, o_busy, o_done, o_xf;
  logic [13:0] o_addr;
  logic [23:0] o_pix;
  logic [23:0] q_pix[$];
  bit q_last[$];
  int q_addr[$];
  int n_over, n_done, n_hold, timed_out;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : d
    logic [23:0] rd;
    pixel_stream_tx #(.PIX_NUM(4 << g), .ADDR_W(14)) u (
      .clk(clk), .reset(reset), .start(start[g]), .abort(abort[g]),
      .mem_addr(addr[g]), .mem_rd_en(rd_en[g]), .mem_rdata(rd),
      .pixel_out(pout[g]), .pixel_valid(valid[g]), .pixel_ready(ready[g]),
      .last_pixel(last[g]),
`ifdef PIXEL_CLASS_EN
      .pixel_class(pclass[g]),
`endif
      .busy(busy[g]), .done(done[g]));
    // picture memory: one-cycle read latency, garbage on the bus when not reading
    always @(posedge clk) rd <= rd_en[g] ? mem[g][addr[g][3:0]] : 24'($urandom);
  end

  // one cycle: drive inputs after the falling edge, sample just after
  task automatic tick(input int i, input bit rdy, input bit st = 0, input bit ab = 0);
    @(negedge clk);
    start[i] = st;
    abort[i] = ab;
    ready[i] = rdy;
    #1;
    o_rd = rd_en[i]; o_addr = addr[i]; o_valid = valid[i]; o_pix = pout[i];
    o_last = last[i]; o_busy = busy[i]; o_done = done[i];
    o_xf = valid[i] & rdy & ~ab;
`ifdef PIXEL_CLASS_EN
    o_cls = pclass[i];
`endif
  endtask

  // run one picture and collect what the consumer and the memory saw
  task automatic run_pic(input int i, input int mode, input int budget, input int stop_at = -1,
                         input int restart_at = -1);
    int out;
    bit rdy, ab, pv, pr, pl;
    logic [23:0] pp;
    q_pix = {}; q_last = {}; q_addr = {};
`ifdef PIXEL_CLASS_EN
    q_cls = {};
`endif
    n_over = 0; n_done = 0; n_hold = 0; timed_out = 1; out = 0;
    pv = 0; pr = 1; pl = 0; pp = '0;
    for (int c = 0; c < budget && timed_out != 0; c++) begin
      rdy = (c == 0 || mode == 0) ? 1'b1 : mode == 1 ? (c % 3 == 1) : 1'($urandom_range(0, 1));
      ab = stop_at >= 0 && q_pix.size() == stop_at;
      tick(i, rdy, c == 0 || c == restart_at, ab);
      if (pv && !pr && (!o_valid || o_pix !== pp || o_last !== pl)) n_hold++;
      if (o_rd && out - int'(o_xf) >= 2) n_over++;
      if (o_rd) q_addr.push_back(int'(o_addr));
      if (o_xf) begin
        q_pix.push_back(o_pix);
        q_last.push_back(o_last);
`ifdef PIXEL_CLASS_EN
        q_cls.push_back(o_cls);
`endif
      end
      out += int'(o_rd) - int'(o_xf);
      if (o_done) n_done++;
      if (o_done || ab) timed_out = 0;
      pv = o_valid; pr = rdy; pp = o_pix; pl = o_last;
    end
  endtask

  task automatic fill(input int i);
    for (int k = 0; k < 16; k++) mem[i][k] = 24'($urandom);
  endtask

  task automatic test_reset();
    vec++;
    if (rd_en !== 3'b0 || valid !== 3'b0 || last !== 3'b0 || busy !== 3'b0 || done !== 3'b0 ||
        addr !== '0 || pout !== '0) begin
      bad++;
      $display("FAIL reset rd=%b valid=%b last=%b busy=%b done=%b, all required 0", rd_en, valid, last, busy, done);
    end
  endtask

  task automatic test_stream4();
    logic ev, el, ed, eb;
    logic [23:0] ep;
    for (int k = 0; k < 4; k++) mem[0][k] = 24'(k + 1);
    tick(0, 1, 1);
    vec++;
    if (o_rd !== 1'b1 || o_addr !== 14'd0) begin
      bad++;
      $display("FAIL stream4_first_read rd=%b addr=%0d, required rd=1 addr=0", o_rd, o_addr);
    end
    for (int c = 1; c <= 7; c++) begin
      tick(0, 1);
      ev = c >= 2 && c <= 5; ep = 24'(c - 1); el = c == 5; ed = c == 6; eb = c <= 5;
      vec++;
      if (o_valid !== ev || (ev && o_pix !== ep) || o_last !== el || o_done !== ed || o_busy !== eb) begin
        bad++;
        $display("FAIL stream4_cycle%0d got v=%b pix=%h last=%b done=%b busy=%b, required v=%b pix=%h last=%b done=%b busy=%b",
                 c, o_valid, o_pix, o_last, o_done, o_busy, ev, ep, el, ed, eb);
      end
    end
  endtask

  task automatic test_backpressure8();
    fill(1);
    run_pic(1, 1, 200);
    vec++;
    if (timed_out != 0 || n_done != 1 || q_pix.size() != 8 || q_addr.size() != 8 || n_over != 0 || n_hold != 0) begin
      bad++;
      $display("FAIL bp8_summary timeout=%0d done=%0d pix=%0d reads=%0d over=%0d hold=%0d, required 0 1 8 8 0 0",
               timed_out, n_done, q_pix.size(), q_addr.size(), n_over, n_hold);
    end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (q_pix[k] !== mem[1][k] || q_last[k] !== (k == 7) || q_addr[k] != k) begin
        bad++;
        $display("FAIL bp8_pixel%0d got %h last=%b addr=%0d, required %h last=%b addr=%0d",
                 k, q_pix[k], q_last[k], q_addr[k], mem[1][k], k == 7, k);
      end
    end
  endtask

  task automatic test_abort16();
    int nd;
    fill(2);
    run_pic(2, 2, 200, 3);
    vec++;
    if (q_pix.size() != 3 || q_pix[0] !== mem[2][0] || q_pix[1] !== mem[2][1] || q_pix[2] !== mem[2][2]) begin
      bad++;
      $display("FAIL abort_prefix got %0d pixels, required 3 matching memory", q_pix.size());
    end
    tick(2, 1);
    vec++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_rd !== 1'b0 || o_addr !== 14'd0) begin
      bad++;
      $display("FAIL abort_after got v=%b busy=%b done=%b rd=%b addr=%0d, required all 0",
               o_valid, o_busy, o_done, o_rd, o_addr);
    end
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      tick(2, 1);
      nd += int'(o_done | o_valid);
    end
    vec++;
    if (nd != 0) begin
      bad++;
      $display("FAIL abort_quiet got %0d done/valid cycles, required 0", nd);
    end
    run_pic(2, 2, 400);
    vec++;
    if (timed_out != 0 || n_done != 1 || q_pix.size() != 16 || q_addr.size() != 16 || n_over != 0 || n_hold != 0) begin
      bad++;
      $display("FAIL abort_rerun timeout=%0d done=%0d pix=%0d reads=%0d over=%0d hold=%0d, required 0 1 16 16 0 0",
               timed_out, n_done, q_pix.size(), q_addr.size(), n_over, n_hold);
    end
    for (int k = 0; k < 16; k++) begin
      vec++;
      if (q_pix[k] !== mem[2][k] || q_last[k] !== (k == 15) || q_addr[k] != k) begin
        bad++;
        $display("FAIL abort_rerun_pixel%0d got %h addr=%0d, required %h addr=%0d", k, q_pix[k], q_addr[k], mem[2][k], k);
      end
    end
  endtask

  task automatic test_async_reset();
    int nb;
    fill(1);
    tick(1, 1, 1);
    for (int c = 0; c < 4; c++) tick(1, 1'($urandom_range(0, 1)));
    #2 reset = 1'b0;
    #1;
    vec++;
    if (rd_en !== 3'b0 || valid !== 3'b0 || last !== 3'b0 || busy !== 3'b0 || done !== 3'b0 ||
        addr !== '0 || pout !== '0) begin
      bad++;
      $display("FAIL async_reset rd=%b valid=%b busy=%b done=%b addr1=%0d pix1=%h, required 0",
               rd_en, valid, busy, done, addr[1], pout[1]);
    end
    @(negedge clk) reset = 1'b1;
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      tick(1, 1);
      nb += int'(o_busy | o_rd | o_valid);
    end
    vec++;
    if (nb != 0) begin
      bad++;
      $display("FAIL reset_no_restart got %0d active cycles, required 0", nb);
    end
    run_pic(1, 2, 200);
    vec++;
    if (timed_out != 0 || n_done != 1 || q_pix.size() != 8 || q_addr.size() != 8 || n_over != 0) begin
      bad++;
      $display("FAIL reset_rerun timeout=%0d done=%0d pix=%0d reads=%0d over=%0d, required 0 1 8 8 0",
               timed_out, n_done, q_pix.size(), q_addr.size(), n_over);
    end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (q_pix[k] !== mem[1][k] || q_addr[k] != k) begin
        bad++;
        $display("FAIL reset_rerun_pixel%0d got %h addr=%0d, required %h addr=%0d", k, q_pix[k], q_addr[k], mem[1][k], k);
      end
    end
  endtask

  task automatic test_start_busy();
    int nd;
    fill(0);
    run_pic(0, 2, 200, -1, 2);
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      tick(0, 1);
      nd += int'(o_done | o_busy);
    end
    vec++;
    if (timed_out != 0 || n_done != 1 || nd != 0 || q_pix.size() != 4 || q_addr.size() != 4 || n_hold != 0) begin
      bad++;
      $display("FAIL start_busy timeout=%0d done=%0d extra=%0d pix=%0d reads=%0d hold=%0d, required 0 1 0 4 4 0",
               timed_out, n_done, nd, q_pix.size(), q_addr.size(), n_hold);
    end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (q_pix[k] !== mem[0][k] || q_last[k] !== (k == 3)) begin
        bad++;
        $display("FAIL start_busy_pixel%0d got %h last=%b, required %h last=%b", k, q_pix[k], q_last[k], mem[0][k], k == 3);
      end
    end
  endtask

  task automatic test_random();
    int i, n, errs;
    for (int r = 0; r < 8; r++) begin
      i = $urandom_range(0, 2);
      n = 4 << i;
      fill(i);
      run_pic(i, $urandom_range(0, 2), 400);
      errs = 0;
      for (int k = 0; k < n; k++)
        errs += int'(q_pix[k] !== mem[i][k] || q_last[k] !== (k == n - 1) || q_addr[k] != k);
      vec++;
      if (timed_out != 0 || n_done != 1 || q_pix.size() != n || q_addr.size() != n || n_over != 0 ||
          n_hold != 0 || errs != 0) begin
        bad++;
        $display("FAIL random%0d dut%0d timeout=%0d done=%0d pix=%0d reads=%0d over=%0d hold=%0d errs=%0d, required 0 1 %0d %0d 0 0 0",
                 r, i, timed_out, n_done, q_pix.size(), q_addr.size(), n_over, n_hold, errs, n, n);
      end
    end
  endtask

`ifdef PIXEL_CLASS_EN
  task automatic test_class();
    logic [1:0] exp_cls[4];
    exp_cls = '{2'b10, 2'b00, 2'b00, 2'b00};
    mem[0][0] = 24'h102030; mem[0][1] = 24'h303010; mem[0][2] = 24'h302010; mem[0][3] = 24'h101010;
    run_pic(0, 0, 50);
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (q_cls[k] !== exp_cls[k]) begin
        bad++;
        $display("FAIL class%0d got %b, required %b", k, q_cls[k], exp_cls[k]);
      end
    end
    mem[0][0] = 24'h10FF20;
    run_pic(0, 2, 100);
    vec++;
    if (q_cls[0] !== 2'b01) begin
      bad++;
      $display("FAIL class_green got %b, required 01", q_cls[0]);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; start = '0; abort = '0; ready = '0;
    #3;
    test_reset();
    @(negedge clk) reset = 1'b1;
    test_stream4();
    test_backpressure8();
    test_abort16();
    test_async_reset();
    test_start_busy();
    test_random();
`ifdef PIXEL_CLASS_EN
    test_class();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameter PIX_NUM, default 16384, pixels per picture (2..2^ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 14, pixel address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins streaming one picture.
REQ-006 SHALL have port abort  input  1  stops the current picture.
REQ-007 SHALL have port mem_addr  output  ADDR_W  picture-memory read address.
REQ-008 SHALL have port mem_rd_en  output  1  picture-memory read strobe; data returns exactly 1 cycle later.
REQ-009 SHALL have port mem_rdata  input  24  returned pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-010 SHALL have port pixel_out  output  24  streamed pixel.
REQ-011 SHALL have port pixel_valid  output  1  pixel_out holds a valid pixel.
REQ-012 SHALL have port pixel_ready  input  1  consumer accepts pixel_out.
REQ-013 SHALL have port last_pixel  output  1  qualifies pixel_out as pixel PIX_NUM-1.
REQ-014 SHALL have ports busy and done  output  1 each  picture in progress / one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN once the read for address PIX_NUM-1 issues; DRAIN -> IDLE when the last pixel is accepted; any state -> IDLE on abort.
REQ-016 SHALL transfer a pixel only in a cycle with pixel_valid=1 and pixel_ready=1.
REQ-017 SHALL hold pixel_out and last_pixel stable while pixel_valid=1 and pixel_ready=0.
REQ-018 SHALL, in RUN, assert mem_rd_en only when in-flight reads plus buffered pixels total fewer than 2; a 1-entry skid buffer behind the output register absorbs the returning read.
REQ-019 SHALL sustain one pixel per cycle when pixel_ready stays high; first pixel_valid 2 cycles after start.
REQ-020 SHALL issue addresses 0..PIX_NUM-1 in order, each exactly once; address counter stops at PIX_NUM-1 without wrapping.
REQ-021 SHALL emit pixels in address order with no loss or duplication under any pixel_ready pattern.
REQ-022 SHALL assert busy from the cycle after start until the cycle after the last transfer.
REQ-023 SHALL pulse done for one cycle in the cycle after the last pixel transfer.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL, on abort, clear pixel_valid, the skid buffer and the address counter next cycle, discard any in-flight read data, and not pulse done.
REQ-026 SHALL give abort priority over a simultaneous start or transfer.

Reset
REQ-027 SHALL on reset=0 asynchronously force IDLE and set mem_addr=0, mem_rd_en=0, pixel_out=0, pixel_valid=0, last_pixel=0, busy=0, done=0, and an empty buffer.
REQ-028 SHALL, after reset mid-picture, restart from address 0 only on a new start.

Configuration
REQ-029 SHALL, with PIXEL_CLASS_EN defined, add output pixel_class[1:0], registered alongside pixel_out: 01 if G>=B and G>R; 10 if B>G and B>R; otherwise 00 (red); reset value 00.
REQ-030 SHALL, without PIXEL_CLASS_EN, have no pixel_class port and no comparator logic.

Verification
REQ-031 SHALL cover: PIX_NUM=4, mem[i]=i+1, pixel_ready=1, start -> pixels 1,2,3,4 on consecutive cycles from start+2, last_pixel with 4, done 1 cycle later.
REQ-032 SHALL cover: PIX_NUM=8, pixel_ready toggling 1,0,0,1,... -> all 8 pixels in order, none repeated, mem_rd_en never raised with 2 pixels pending.
REQ-033 SHALL cover: abort after 3 transfers of 16 -> pixel_valid=0 next cycle, no done, busy=0; new start re-reads from address 0.
REQ-034 SHALL cover: reset=0 asserted mid-picture between clock edges -> all outputs at reset values immediately.
REQ-035 SHALL cover: start pulsed while busy -> no effect, exactly PIX_NUM transfers, one done pulse.
REQ-036 SHALL cover, with PIXEL_CLASS_EN: pixels 0x102030, 0x303010, 0x302010, 0x101010 -> pixel_class 10, 00, 00, 00; 0x10FF20 -> 01.
